// File: rtl/ram_dp_param_clr.sv
// Simple dual-port RAM (one write port, one read port, single clock) with byte enables,
// selectable read-during-write behaviour, optional output register and a clear sweeper.
module ram_dp_param_clr #(
    parameter int                DATA_W   = 64,
    parameter int                ADDR_W   = 8,
    parameter int                OUT_REG  = 0,
    parameter int                RDW_MODE = 0,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_req,
    output logic                busy,
    input  logic                we,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [ADDR_W-1:0]   write_addr,
    input  logic [DATA_W-1:0]   din,
    input  logic                re,
    input  logic [ADDR_W-1:0]   read_addr,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_valid
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int BE_W  = DATA_W/8;

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_en;
    logic              rd_acc;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] rd_data_p0;
    logic              vld_p0;

    function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                      input logic [DATA_W-1:0] new_w,
                                                      input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // A clear request wins over a same-cycle write; reads are still accepted.
    assign wr_en  = (state_q == S_READY) && we && !clr_req;
    assign rd_acc = (state_q == S_READY) && re;
    assign busy   = (state_q == S_CLEAR);

    always_comb begin
        rd_word = mem[read_addr];
        if ((RDW_MODE != 0) && wr_en && (read_addr == write_addr)) begin
            rd_word = merge_bytes(mem[read_addr], din, wbe);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_CLEAR: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == '1) state_d = S_READY;
            end
            S_READY: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage has no reset; the sweeper owns the write port while clearing.
    always_ff @(posedge clk) begin
        if (state_q == S_CLEAR) begin
            mem[cnt_q] <= CLR_VAL;
        end else if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wbe[i]) mem[write_addr][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    // Stage p0: array read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_p0 <= '0;
            vld_p0     <= 1'b0;
        end else begin
            vld_p0 <= rd_acc;
            if (rd_acc) rd_data_p0 <= rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] rd_data_p1;
            logic              vld_p1;

            // Stage p1: output register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_p1 <= '0;
                    vld_p1     <= 1'b0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) rd_data_p1 <= rd_data_p0;
                end
            end

            assign dout       = rd_data_p1;
            assign dout_valid = vld_p1;
        end else begin : g_no_out_reg
            assign dout       = rd_data_p0;
            assign dout_valid = vld_p0;
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_param_clr.sv
// Directed bench for ram_dp_param_clr: three instances share stimulus
// (old-data RDW, write-through RDW with nonzero clear value, output-registered).
module tb_ram_dp_param_clr;

    localparam int              DW    = 64;
    localparam int              AW    = 8;
    localparam logic [DW-1:0]   CLR_R = 64'h0123_4567_89AB_CDEF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr_req;
    logic          we;
    logic [DW/8-1:0] wbe;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] din;
    logic          re;
    logic [AW-1:0] read_addr;

    logic          busy_a, busy_b, busy_c;
    logic [DW-1:0] dout_a, dout_b, dout_c;
    logic          dv_a, dv_b, dv_c;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ram_dp_param_clr #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(0), .CLR_VAL('0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_a), .we(we), .wbe(wbe),
        .write_addr(write_addr), .din(din), .re(re), .read_addr(read_addr),
        .dout(dout_a), .dout_valid(dv_a));

    ram_dp_param_clr #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(0), .RDW_MODE(1), .CLR_VAL(CLR_R)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_b), .we(we), .wbe(wbe),
        .write_addr(write_addr), .din(din), .re(re), .read_addr(read_addr),
        .dout(dout_b), .dout_valid(dv_b));

    ram_dp_param_clr #(.DATA_W(DW), .ADDR_W(AW), .OUT_REG(1), .RDW_MODE(0), .CLR_VAL('0)) dut_c (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .busy(busy_c), .we(we), .wbe(wbe),
        .write_addr(write_addr), .din(din), .re(re), .read_addr(read_addr),
        .dout(dout_c), .dout_valid(dv_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int n;
        logic [AW-1:0] addrs [3];
        addrs[0] = 8'h00; addrs[1] = 8'h7F; addrs[2] = 8'hFF;
        rst_n = 1'b0; clr_req = 0; we = 0; wbe = '0; write_addr = '0; din = '0; re = 0; read_addr = '0;
        #12;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy_a); else n_pass++;
        n_checks++; if (dout_c !== '0) $display("FAIL reset_dout: got %h expected 0", dout_c); else n_pass++;
        n_checks++; if (dv_a !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dv_a); else n_pass++;
        #11;
        rst_n = 1'b1;
        n = 0;
        while (n < 400) begin
            step();
            n++;
            if (!busy_a) break;
        end
        n_checks++; if (n !== 256) $display("FAIL reset_sweep_len: got %0d edges expected 256", n); else n_pass++;
        n_checks++; if (busy_b !== 1'b0) $display("FAIL reset_busy_b: got %b expected 0", busy_b); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            re = 1; read_addr = addrs[k];
            step();
            re = 0;
            n_checks++; if (dout_a !== '0) $display("FAIL reset_read_a[%h]: got %h expected 0", addrs[k], dout_a); else n_pass++;
            n_checks++; if (dout_b !== CLR_R) $display("FAIL reset_read_b[%h]: got %h expected %h", addrs[k], dout_b, CLR_R); else n_pass++;
            n_checks++; if (dv_a !== 1'b1) $display("FAIL reset_read_valid[%h]: got %b expected 1", addrs[k], dv_a); else n_pass++;
            step();
            n_checks++; if (dv_a !== 1'b0) $display("FAIL reset_read_pulse[%h]: got %b expected 0", addrs[k], dv_a); else n_pass++;
        end
    endtask

    task automatic test_byte_enable();
        we = 1; write_addr = 8'h10; din = 64'h1122_3344_5566_7788; wbe = 8'hFF;
        step();
        din = 64'hAAAA_AAAA_AAAA_AAAA; wbe = 8'h0F;
        step();
        we = 0; re = 1; read_addr = 8'h10;
        step();
        re = 0;
        n_checks++; if (dout_a !== 64'h1122_3344_AAAA_AAAA) $display("FAIL byte_en_a: got %h expected 1122334 4aaaaaaaa", dout_a); else n_pass++;
        n_checks++; if (dout_b !== 64'h1122_3344_AAAA_AAAA) $display("FAIL byte_en_b: got %h expected 11223344aaaaaaaa", dout_b); else n_pass++;
        we = 1; wbe = 8'h00; din = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        we = 0; re = 1;
        step();
        re = 0;
        n_checks++; if (dout_a !== 64'h1122_3344_AAAA_AAAA) $display("FAIL byte_en_zero: got %h expected 11223344aaaaaaaa", dout_a); else n_pass++;
        step();
    endtask

    task automatic test_rdw();
        we = 1; wbe = 8'hFF; write_addr = 8'h20; din = 64'hDEAD_BEEF_0000_0001;
        re = 1; read_addr = 8'h20;
        step();
        we = 0;
        n_checks++; if (dout_a !== 64'h0) $display("FAIL rdw_old: got %h expected 0", dout_a); else n_pass++;
        n_checks++; if (dout_b !== 64'hDEAD_BEEF_0000_0001) $display("FAIL rdw_new: got %h expected deadbeef00000001", dout_b); else n_pass++;
        step();
        re = 0;
        n_checks++; if (dout_a !== 64'hDEAD_BEEF_0000_0001) $display("FAIL rdw_next_a: got %h expected deadbeef00000001", dout_a); else n_pass++;
        n_checks++; if (dout_b !== 64'hDEAD_BEEF_0000_0001) $display("FAIL rdw_next_b: got %h expected deadbeef00000001", dout_b); else n_pass++;
        step();
    endtask

    task automatic test_back_to_back();
        we = 1; wbe = 8'hFF;
        write_addr = 8'h01; din = 64'hA; step();
        write_addr = 8'h02; din = 64'hB; step();
        write_addr = 8'h03; din = 64'hC; step();
        we = 0;
        step();
        step();
        re = 1; read_addr = 8'h01; step();
        n_checks++; if (dv_c !== 1'b0) $display("FAIL oreg_e1_valid: got %b expected 0", dv_c); else n_pass++;
        n_checks++; if (dout_a !== 64'hA || dv_a !== 1'b1) $display("FAIL lat1_e1: got %h/%b expected a/1", dout_a, dv_a); else n_pass++;
        read_addr = 8'h02; step();
        n_checks++; if (dout_c !== 64'hA || dv_c !== 1'b1) $display("FAIL oreg_e2: got %h/%b expected a/1", dout_c, dv_c); else n_pass++;
        n_checks++; if (dout_a !== 64'hB) $display("FAIL lat1_e2: got %h expected b", dout_a); else n_pass++;
        read_addr = 8'h03; step();
        n_checks++; if (dout_c !== 64'hB || dv_c !== 1'b1) $display("FAIL oreg_e3: got %h/%b expected b/1", dout_c, dv_c); else n_pass++;
        n_checks++; if (dout_a !== 64'hC) $display("FAIL lat1_e3: got %h expected c", dout_a); else n_pass++;
        re = 0; step();
        n_checks++; if (dout_c !== 64'hC || dv_c !== 1'b1) $display("FAIL oreg_e4: got %h/%b expected c/1", dout_c, dv_c); else n_pass++;
        n_checks++; if (dv_a !== 1'b0 || dout_a !== 64'hC) $display("FAIL lat1_hold: got %h/%b expected c/0", dout_a, dv_a); else n_pass++;
        step();
        n_checks++; if (dv_c !== 1'b0 || dout_c !== 64'hC) $display("FAIL oreg_e5: got %h/%b expected c/0", dout_c, dv_c); else n_pass++;
    endtask

    task automatic test_clear();
        int n;
        int saw_valid;
        int dout_moved;
        we = 1; wbe = 8'hFF; write_addr = 8'h05; din = 64'h5555_5555_5555_5555; clr_req = 1; re = 0;
        step();
        clr_req = 0;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL clear_start_busy: got %b expected 1", busy_a); else n_pass++;
        write_addr = 8'h00; din = 64'h7777_7777_7777_7777; re = 1; read_addr = 8'h10;
        n = 0; saw_valid = 0; dout_moved = 0;
        while (n < 400) begin
            step();
            n++;
            if (dv_a || dv_b || dv_c) saw_valid++;
            if (dout_a !== 64'hC) dout_moved++;
            if (!busy_a) break;
        end
        we = 0; re = 0;
        n_checks++; if (n !== 256) $display("FAIL clear_len: got %0d edges expected 256", n); else n_pass++;
        n_checks++; if (saw_valid !== 0) $display("FAIL clear_valid: got %0d pulses expected 0", saw_valid); else n_pass++;
        n_checks++; if (dout_moved !== 0) $display("FAIL clear_dout_hold: got %0d changes expected 0", dout_moved); else n_pass++;
        re = 1; read_addr = 8'h05; step();
        n_checks++; if (dout_a !== '0) $display("FAIL clear_addr05_a: got %h expected 0", dout_a); else n_pass++;
        n_checks++; if (dout_b !== CLR_R) $display("FAIL clear_addr05_b: got %h expected %h", dout_b, CLR_R); else n_pass++;
        read_addr = 8'h00; step();
        n_checks++; if (dout_a !== '0) $display("FAIL clear_addr00: got %h expected 0", dout_a); else n_pass++;
        read_addr = 8'h10; step();
        re = 0;
        n_checks++; if (dout_b !== CLR_R) $display("FAIL clear_addr10: got %h expected %h", dout_b, CLR_R); else n_pass++;
        step();
        step();
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        clr_req = 1; step();
        clr_req = 0;
        repeat (100) step();
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy_a !== 1'b1) $display("FAIL midrst_busy: got %b expected 1", busy_a); else n_pass++;
        n_checks++; if (dout_b !== '0) $display("FAIL midrst_dout: got %h expected 0", dout_b); else n_pass++;
        n_checks++; if (dv_a !== 1'b0 || dv_c !== 1'b0) $display("FAIL midrst_valid: got %b%b expected 00", dv_a, dv_c); else n_pass++;
        #10;
        rst_n = 1'b1;
        n = 0;
        while (n < 400) begin
            step();
            n++;
            if (!busy_a) break;
        end
        n_checks++; if (n !== 256) $display("FAIL midrst_sweep_len: got %0d edges expected 256", n); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_rdw();
        test_back_to_back();
        test_clear();
        test_reset_mid_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
